intc_ext: RTL and testbench

- Interrupt controller feeding the OTTER MCU core; the request side of the interrupt handshake whose acknowledge/return side lives in the core's CSR logic.
- Synchronizes NUM_SRC asynchronous external interrupt lines, detects rising edges, latches them as pending, and picks one by fixed priority.
- Raises INTR to the core while the core's global enable (MIE) is set.
- Tracks the interrupt through INT_TAKEN (entry) and MRET_EXEC (return).

---
 rtl/intc_pkg.sv | 27 ++
 rtl/intc_sync_edge.sv | 35 +++
 rtl/intc_ext.sv | 139 +++++++++++++
 tb/tb_intc_ext.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// intc_pkg: shared types and helpers for the intc_ext interrupt controller.
//   state_t      - controller state encoding (IDLE, REQ, SERVICE)
//   lowest_index - index of the lowest set bit of a request vector (0 if none)
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam int MAX_SRC = 32;

    // Callers zero-extend their NUM_SRC-wide vector to 32 bits. Scanning from
    // the top down leaves the lowest set index as the final assignment.
    function automatic logic [4:0] lowest_index(input logic [MAX_SRC-1:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/intc_sync_edge.sv
// intc_sync_edge: one-bit synchronizer followed by a delay flop; emits a
// one-cycle pulse when the synchronized line goes from 0 to 1.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   irq        in  asynchronous interrupt line
//   edge_pulse out one-cycle rising-edge pulse (combinational from flops)
module intc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   delay_reg;
    logic                   sync_out;

    assign sync_out = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            delay_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], irq};
            delay_reg <= sync_out;
        end
    end

    assign edge_pulse = sync_out & ~delay_reg;

endmodule

// File: rtl/intc_ext.sv
// intc_ext: external interrupt controller for the OTTER core.
// Synchronizes NUM_SRC lines, latches rising edges as pending, selects the
// lowest-index eligible source and runs a REQ/SERVICE handshake with the core.
// Build option: define INTC_MASK_EN to make the source mask writable;
// otherwise the mask is fixed at all ones and MASK_WE/MASK_WD are ignored.
// Ports:
//   CLK, RST_N  clock / asynchronous active-low reset
//   IRQ_IN      asynchronous interrupt lines (rising-edge significant)
//   MIE         global interrupt enable from core
//   INT_TAKEN   core vectored to the handler this cycle
//   MRET_EXEC   core executing mret this cycle
//   MASK_WE/WD  mask write strobe / data (1 = source enabled)
//   INTR        interrupt request to core
//   CAUSE       index of selected / in-service source
//   PENDING     pending bits
//   BUSY        handler in service
module intc_ext
    import intc_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    input  logic               MIE,
    input  logic               INT_TAKEN,
    input  logic               MRET_EXEC,
    input  logic               MASK_WE,
    input  logic [NUM_SRC-1:0] MASK_WD,
    output logic               INTR,
    output logic [CW-1:0]      CAUSE,
    output logic [NUM_SRC-1:0] PENDING,
    output logic               BUSY
);

    state_t               state_reg, state_next;
    logic [CW-1:0]        cause_reg, cause_next;
    logic [NUM_SRC-1:0]   pending_reg, pending_next;
    logic                 intr_reg, busy_reg;
    logic [NUM_SRC-1:0]   edge_vec;
    logic [NUM_SRC-1:0]   mask;
    logic [NUM_SRC-1:0]   eligible;
    logic [NUM_SRC-1:0]   clr_vec;
    logic [CW-1:0]        win_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            intc_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync_edge (
                .clk       (CLK),
                .rst_n     (RST_N),
                .irq       (IRQ_IN[gi]),
                .edge_pulse(edge_vec[gi])
            );
        end
    endgenerate

`ifdef INTC_MASK_EN
    logic [NUM_SRC-1:0] mask_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mask_reg <= '1;
        end else if (MASK_WE) begin
            mask_reg <= MASK_WD;
        end
    end

    assign mask = mask_reg;
`else
    assign mask = '1;
    logic unused_mask_ports;
    assign unused_mask_ports = &{1'b0, MASK_WE, MASK_WD};
`endif

    // Masking only gates arbitration; masked sources still latch pending.
    assign eligible = pending_reg & mask;
    assign win_idx  = CW'(lowest_index(32'(eligible)));

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        clr_vec    = '0;
        case (state_reg)
            IDLE: begin
                if (MIE && |eligible) begin
                    state_next = REQ;
                    cause_next = win_idx;
                end
            end
            REQ: begin
                // Acceptance beats a same-cycle MIE drop; CAUSE stays frozen.
                if (INT_TAKEN) begin
                    state_next = SERVICE;
                    clr_vec    = NUM_SRC'(1) << cause_reg;
                end else if (!MIE) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (MRET_EXEC) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A new edge arriving with the clear wins, so that event is kept.
    assign pending_next = (pending_reg & ~clr_vec) | edge_vec;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= IDLE;
            cause_reg   <= '0;
            pending_reg <= '0;
            intr_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cause_reg   <= cause_next;
            pending_reg <= pending_next;
            intr_reg    <= (state_next == REQ);
            busy_reg    <= (state_next == SERVICE);
        end
    end

    assign INTR    = intr_reg;
    assign CAUSE   = cause_reg;
    assign PENDING = pending_reg;
    assign BUSY    = busy_reg;

endmodule

// File: tb/tb_intc_ext.sv
module tb_intc_ext;

    logic       CLK;
    logic       RST_N;
    logic [3:0] IRQ_IN;
    logic       MIE;
    logic       INT_TAKEN;
    logic       MRET_EXEC;
    logic       MASK_WE;
    logic [3:0] MASK_WD;
    logic       INTR;
    logic [1:0] CAUSE;
    logic [3:0] PENDING;
    logic       BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    intc_ext #(.NUM_SRC(4), .SYNC_STAGES(2)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IRQ_IN   (IRQ_IN),
        .MIE      (MIE),
        .INT_TAKEN(INT_TAKEN),
        .MRET_EXEC(MRET_EXEC),
        .MASK_WE  (MASK_WE),
        .MASK_WD  (MASK_WD),
        .INTR     (INTR),
        .CAUSE    (CAUSE),
        .PENDING  (PENDING),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse_taken();
        INT_TAKEN = 1'b1;
        tick();
        INT_TAKEN = 1'b0;
    endtask

    task automatic pulse_mret();
        MRET_EXEC = 1'b1;
        tick();
        MRET_EXEC = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; IRQ_IN = '0; MIE = 1'b0; INT_TAKEN = 1'b0;
        MRET_EXEC = 1'b0; MASK_WE = 1'b0; MASK_WD = '0;
        tick(2);
        chk("rst_intr", INTR, 0);
        chk("rst_pend", PENDING, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_cause", CAUSE, 0);
        RST_N = 1'b1;
        tick();

        // Single source 2: three edges to pending, one more to INTR.
        MIE = 1'b1;
        IRQ_IN = 4'b0100;
        tick(2);
        chk("t1_pend_e2", PENDING, 4'b0000);
        tick();
        chk("t1_pend_e3", PENDING, 4'b0100);
        chk("t1_intr_e3", INTR, 0);
        tick();
        chk("t1_intr", INTR, 1);
        chk("t1_cause", CAUSE, 2);
        chk("t1_busy_req", BUSY, 0);
        pulse_taken();
        chk("t1_pend_clr", PENDING, 0);
        chk("t1_intr_tk", INTR, 0);
        chk("t1_busy", BUSY, 1);
        tick(2);
        chk("t1_busy_hold", BUSY, 1);
        pulse_mret();
        chk("t1_busy_mret", BUSY, 0);
        tick();
        chk("t1_idle_intr", INTR, 0);

        // Sources 3 and 1 together: 1 first, then 3.
        IRQ_IN = 4'b1110;
        tick(3);
        chk("t2_pend", PENDING, 4'b1010);
        tick();
        chk("t2_intr", INTR, 1);
        chk("t2_cause1", CAUSE, 1);
        pulse_taken();
        chk("t2_pend_tk", PENDING, 4'b1000);
        chk("t2_busy", BUSY, 1);
        pulse_mret();
        chk("t2_busy_mret", BUSY, 0);
        chk("t2_no_pulse", INTR, 0);
        tick();
        chk("t2_intr2", INTR, 1);
        chk("t2_cause3", CAUSE, 3);

        // Higher-priority source 0 arrives during REQ for 3: no preemption.
        IRQ_IN = 4'b1111;
        tick(3);
        chk("t3_pend", PENDING, 4'b1001);
        chk("t3_cause_fz", CAUSE, 3);
        chk("t3_intr", INTR, 1);
        pulse_taken();
        chk("t3_pend_tk", PENDING, 4'b0001);
        chk("t3_cause_svc", CAUSE, 3);
        pulse_mret();
        tick();
        chk("t3_intr0", INTR, 1);
        chk("t3_cause0", CAUSE, 0);
        pulse_taken();
        chk("t3_pend_0", PENDING, 0);
        pulse_mret();

        // MIE gating: pending held while MIE=0, REQ withdrawn on MIE drop.
        MIE = 1'b0;
        IRQ_IN = 4'b0000;
        tick(3);
        IRQ_IN = 4'b0010;
        tick(4);
        chk("t4_pend", PENDING, 4'b0010);
        chk("t4_intr_off", INTR, 0);
        MIE = 1'b1;
        tick();
        chk("t4_intr_on", INTR, 1);
        chk("t4_cause", CAUSE, 1);
        MIE = 1'b0;
        tick();
        chk("t4_intr_drop", INTR, 0);
        chk("t4_pend_keep", PENDING, 4'b0010);
        chk("t4_busy", BUSY, 0);

        // INT_TAKEN beats a same-cycle MIE drop.
        MIE = 1'b1;
        tick();
        chk("t5_intr", INTR, 1);
        MIE = 1'b0;
        INT_TAKEN = 1'b1;
        tick();
        INT_TAKEN = 1'b0;
        MIE = 1'b1;
        chk("t5_tk_prio", BUSY, 1);
        chk("t5_pend_clr", PENDING, 0);

        // Re-rise of source 1 during SERVICE: pending, no nesting.
        IRQ_IN = 4'b0000;
        tick(3);
        IRQ_IN = 4'b0010;
        tick(3);
        chk("t5_pend_svc", PENDING, 4'b0010);
        chk("t5_intr_svc", INTR, 0);
        chk("t5_busy_svc", BUSY, 1);
        tick();
        chk("t5_no_nest", INTR, 0);
        pulse_mret();
        chk("t5_mret_intr", INTR, 0);
        chk("t5_mret_busy", BUSY, 0);
        tick();
        chk("t5_req", INTR, 1);
        chk("t5_req_cause", CAUSE, 1);

        // Asynchronous reset mid-REQ, observed before the next clock edge.
        #2;
        RST_N = 1'b0;
        #1;
        chk("ar_intr", INTR, 0);
        chk("ar_pend", PENDING, 0);
        chk("ar_busy", BUSY, 0);
        chk("ar_cause", CAUSE, 0);
        IRQ_IN = 4'b0000;
        tick();
        RST_N = 1'b1;
        tick(3);
        chk("ar_after", PENDING, 0);

`ifdef INTC_MASK_EN
        MIE = 1'b1;
        MASK_WE = 1'b1;
        MASK_WD = 4'b1011;
        tick();
        MASK_WE = 1'b0;
        IRQ_IN = 4'b0100;
        tick(3);
        chk("mk_pend", PENDING, 4'b0100);
        tick();
        chk("mk_intr_off", INTR, 0);
        MASK_WE = 1'b1;
        MASK_WD = 4'b1111;
        tick();
        MASK_WE = 1'b0;
        chk("mk_intr_lat", INTR, 0);
        tick();
        chk("mk_intr_on", INTR, 1);
        chk("mk_cause", CAUSE, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
